vx_fill_collector: RTL and testbench

Assembles narrow memory-response beats into full cache lines and hands each completed line, with its line address, to a cache bank's data-store fill path. Sits between the memory-response demux and a bank's data-access stage. Contains a two-deep buffer (assembly register plus output slot), so collection of line N+1 overlaps the bank's acceptance of line N. One instance per bank.

---
 rtl/vx_fill_pkg.sv | 34 +++
 rtl/vx_fill_slot.sv | 41 ++++
 rtl/vx_fill_collector.sv | 139 +++++++++++++
 tb/tb_vx_fill_collector.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vx_fill_pkg.sv
// Shared definitions for the fill collector.
// Contents:
//   calc_beats / calc_sel_bits : derive beat count and beat-select width
//                                from the line and beat widths.
//   BEATS / BEAT_SEL_BITS      : values for the default 64-byte line with
//                                128-bit memory beats.
//   line_t                     : line-data type for the default geometry.
//   fill_state_e               : collector FSM states.
package vx_fill_pkg;

  function automatic int calc_beats(input int line_w, input int mem_w);
    return line_w / mem_w;
  endfunction

  // Width of the beat-select field, kept at least 1 bit so a single-beat
  // configuration still has a legal (constant-zero) counter.
  function automatic int calc_sel_bits(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int DFLT_LINE_WIDTH     = 8 * 64;
  localparam int DFLT_MEM_DATA_WIDTH = 128;
  localparam int BEATS               = calc_beats(DFLT_LINE_WIDTH, DFLT_MEM_DATA_WIDTH);
  localparam int BEAT_SEL_BITS       = calc_sel_bits(BEATS);

  typedef logic [DFLT_LINE_WIDTH-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } fill_state_e;

endpackage

// File: rtl/vx_fill_slot.sv
// Single-entry valid/ready holding register driving a bank's fill port.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset.
//   load                 : capture load_data/load_addr and raise fill_valid.
//   load_data, load_addr : line and line address to hold.
//   fill_ready           : bank accepts the held line.
//   fill_valid, fill_addr, fill_data : held line presented to the bank.
// The caller only asserts load when the slot is empty or being drained in
// the same cycle; a load takes priority over the drain.
module vx_fill_slot
  import vx_fill_pkg::*;
#(
  parameter int LINE_W = 512,
  parameter int ADDR_W = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LINE_W-1:0] load_data,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              fill_ready,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_data  <= '0;
    end else if (load) begin
      fill_valid <= 1'b1;
      fill_addr  <= load_addr;
      fill_data  <= load_data;
    end else if (fill_ready) begin
      fill_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vx_fill_collector.sv
// Assembles memory-response beats into cache lines for one bank's fill path.
// Ports:
//   clk, reset                      : clock, asynchronous active-low reset.
//   mem_rsp_valid/data/addr/ready   : incoming beats, accepted on valid&&ready.
//   fill_valid/addr/data/ready      : completed line handed to the bank.
//   tag_err                         : sticky, set when a non-zero beat carries
//                                     a line address different from beat 0.
//   busy                            : a line is in assembly or being held.
// The assembly register plus the output slot form a two-deep buffer, so the
// next line is collected while the bank is still taking the previous one.
module vx_fill_collector
  import vx_fill_pkg::*;
#(
  parameter int CACHE_LINE_SIZE = 64,
  parameter int MEM_DATA_WIDTH  = 128,
  parameter int LINE_ADDR_WIDTH = 26
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mem_rsp_valid,
  input  logic [MEM_DATA_WIDTH-1:0]    mem_rsp_data,
  input  logic [LINE_ADDR_WIDTH-1:0]   mem_rsp_addr,
  output logic                         mem_rsp_ready,
  output logic                         fill_valid,
  output logic [LINE_ADDR_WIDTH-1:0]   fill_addr,
  output logic [8*CACHE_LINE_SIZE-1:0] fill_data,
  input  logic                         fill_ready,
  output logic                         tag_err,
  output logic                         busy
);

  localparam int LINE_W  = 8 * CACHE_LINE_SIZE;
  localparam int N_BEATS = calc_beats(LINE_W, MEM_DATA_WIDTH);
  localparam int SEL_W   = calc_sel_bits(N_BEATS);

  fill_state_e                state_q;
  logic [SEL_W-1:0]           cnt_q;
  logic [LINE_W-1:0]          asm_q;
  logic [LINE_W-1:0]          asm_nxt;
  logic [LINE_ADDR_WIDTH-1:0] asm_addr_q;
  logic [LINE_ADDR_WIDTH-1:0] beat_addr;
  logic                       tag_err_q;
  logic                       accept;
  logic                       last_beat;
  logic                       slot_free;
  logic                       load;
  logic [LINE_W-1:0]          load_data;
  logic [LINE_ADDR_WIDTH-1:0] load_addr;

  // Ready depends on state only, so the bank's ready never ripples back
  // into the memory-response path combinationally.
  assign mem_rsp_ready = (state_q != FULL) && reset;
  assign accept        = mem_rsp_valid && mem_rsp_ready;
  assign last_beat     = (int'(cnt_q) == N_BEATS - 1);
  assign slot_free     = !fill_valid || fill_ready;
  assign tag_err       = tag_err_q;
  assign busy          = (state_q != IDLE) || fill_valid;

  // Beat 0 names the line; later beats are filed under the captured address
  // even when their own address disagrees.
  assign beat_addr = (cnt_q == '0) ? mem_rsp_addr : asm_addr_q;

  // Assembly register with the current beat merged into its slot.
  always_comb begin
    asm_nxt = asm_q;
    for (int k = 0; k < N_BEATS; k++) begin
      if (int'(cnt_q) == k) begin
        asm_nxt[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_rsp_data;
      end
    end
  end

  // Slot load: either drain a completed line parked in FULL, or bypass the
  // assembly register when the last beat arrives and the slot can take it.
  always_comb begin
    load      = 1'b0;
    load_data = asm_nxt;
    load_addr = beat_addr;
    if (state_q == FULL) begin
      load      = slot_free;
      load_data = asm_q;
      load_addr = asm_addr_q;
    end else if (accept && last_beat && slot_free) begin
      load = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      asm_q      <= '0;
      asm_addr_q <= '0;
      tag_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, COLLECT: begin
          if (accept) begin
            asm_q <= asm_nxt;
            if (cnt_q == '0) begin
              asm_addr_q <= mem_rsp_addr;
            end else if (mem_rsp_addr != asm_addr_q) begin
              tag_err_q <= 1'b1;
            end
            if (last_beat) begin
              cnt_q   <= '0;
              state_q <= slot_free ? IDLE : FULL;
            end else begin
              cnt_q   <= cnt_q + SEL_W'(1);
              state_q <= COLLECT;
            end
          end
        end
        FULL: begin
          if (slot_free) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  vx_fill_slot #(
    .LINE_W (LINE_W),
    .ADDR_W (LINE_ADDR_WIDTH)
  ) u_slot (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_data  (load_data),
    .load_addr  (load_addr),
    .fill_ready (fill_ready),
    .fill_valid (fill_valid),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data)
  );

endmodule

// File: tb/tb_vx_fill_collector.sv
module tb_vx_fill_collector;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Four-beat instance (128-bit beats, 512-bit line)
  logic         va;
  logic [127:0] da;
  logic [25:0]  aa;
  logic         rdya;
  logic         fva;
  logic [25:0]  faa;
  logic [511:0] fda;
  logic         fra;
  logic         taga;
  logic         busya;

  // Single-beat instance (512-bit beats)
  logic         vb;
  logic [511:0] db;
  logic [25:0]  ab;
  logic         rdyb;
  logic         fvb;
  logic [25:0]  fab;
  logic [511:0] fdb;
  logic         frb;
  logic         tagb;
  logic         busyb;

  vx_fill_collector #(.CACHE_LINE_SIZE(64), .MEM_DATA_WIDTH(128), .LINE_ADDR_WIDTH(26)) dut_a (
    .clk(clk), .reset(reset),
    .mem_rsp_valid(va), .mem_rsp_data(da), .mem_rsp_addr(aa), .mem_rsp_ready(rdya),
    .fill_valid(fva), .fill_addr(faa), .fill_data(fda), .fill_ready(fra),
    .tag_err(taga), .busy(busya)
  );

  vx_fill_collector #(.CACHE_LINE_SIZE(64), .MEM_DATA_WIDTH(512), .LINE_ADDR_WIDTH(26)) dut_b (
    .clk(clk), .reset(reset),
    .mem_rsp_valid(vb), .mem_rsp_data(db), .mem_rsp_addr(ab), .mem_rsp_ready(rdyb),
    .fill_valid(fvb), .fill_addr(fab), .fill_data(fdb), .fill_ready(frb),
    .tag_err(tagb), .busy(busyb)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        v;
    logic [31:0] w;
    logic [25:0] a;
    logic        fr;
    logic        efv;
    logic [25:0] efa;
    logic        erdy;
    logic        ebusy;
    logic [31:0] ed0;
    logic [31:0] ed3;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic v, input logic [31:0] w, input logic [25:0] a, input logic fr,
                     input logic efv, input logic [25:0] efa, input logic erdy, input logic ebusy,
                     input logic [31:0] ed0, input logic [31:0] ed3);
    vec_t r;
    r.v = v; r.w = w; r.a = a; r.fr = fr;
    r.efv = efv; r.efa = efa; r.erdy = erdy; r.ebusy = ebusy; r.ed0 = ed0; r.ed3 = ed3;
    vt.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input logic [31:0] w, input logic [25:0] a);
    va = 1'b1;
    da = {96'd0, w};
    aa = a;
    tick();
    va = 1'b0;
  endtask

  initial begin
    va = 0; da = '0; aa = '0; fra = 1'b1;
    vb = 0; db = '0; ab = '0; frb = 1'b0;

    // Reset state
    #2;
    chk("reset fill_valid", 64'(fva), 64'd0);
    chk("reset fill_addr", 64'(faa), 64'd0);
    chk("reset fill_data", 64'(fda[63:0]), 64'd0);
    chk("reset tag_err", 64'(taga), 64'd0);
    chk("reset busy", 64'(busya), 64'd0);
    chk("reset ready low", 64'(rdya), 64'd0);
    chk("reset ready low b", 64'(rdyb), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("ready after release", 64'(rdya), 64'd1);

    // Basic line at 0x123, fill_ready high
    add(1, 32'h1, 26'h123, 1, 0, 0, 1, 1, 0, 0);
    add(1, 32'h2, 26'h123, 1, 0, 0, 1, 1, 0, 0);
    add(1, 32'h3, 26'h123, 1, 0, 0, 1, 1, 0, 0);
    add(1, 32'h4, 26'h123, 1, 1, 26'h123, 1, 1, 32'h1, 32'h4);
    add(0, 32'h0, 26'h0,   1, 0, 0, 1, 0, 0, 0);
    // Back-to-back lines 0x10, 0x11
    add(1, 32'h100, 26'h10, 1, 0, 0, 1, 1, 0, 0);
    add(1, 32'h101, 26'h10, 1, 0, 0, 1, 1, 0, 0);
    add(1, 32'h102, 26'h10, 1, 0, 0, 1, 1, 0, 0);
    add(1, 32'h103, 26'h10, 1, 1, 26'h10, 1, 1, 32'h100, 32'h103);
    add(1, 32'h110, 26'h11, 1, 0, 0, 1, 1, 0, 0);
    add(1, 32'h111, 26'h11, 1, 0, 0, 1, 1, 0, 0);
    add(1, 32'h112, 26'h11, 1, 0, 0, 1, 1, 0, 0);
    add(1, 32'h113, 26'h11, 1, 1, 26'h11, 1, 1, 32'h110, 32'h113);
    add(0, 32'h0, 26'h0,    1, 0, 0, 1, 0, 0, 0);
    // Bank stall: 12 cycles of fill_ready low
    add(1, 32'h200, 26'h10, 0, 0, 0, 1, 1, 0, 0);
    add(1, 32'h201, 26'h10, 0, 0, 0, 1, 1, 0, 0);
    add(1, 32'h202, 26'h10, 0, 0, 0, 1, 1, 0, 0);
    add(1, 32'h203, 26'h10, 0, 1, 26'h10, 1, 1, 32'h200, 32'h203);
    add(1, 32'h210, 26'h11, 0, 1, 26'h10, 1, 1, 32'h200, 32'h203);
    add(1, 32'h211, 26'h11, 0, 1, 26'h10, 1, 1, 32'h200, 32'h203);
    add(1, 32'h212, 26'h11, 0, 1, 26'h10, 1, 1, 32'h200, 32'h203);
    add(1, 32'h213, 26'h11, 0, 1, 26'h10, 0, 1, 32'h200, 32'h203);
    for (int i = 0; i < 4; i++)
      add(1, 32'h2F0, 26'h12, 0, 1, 26'h10, 0, 1, 32'h200, 32'h203);
    add(0, 32'h0, 26'h0, 1, 1, 26'h11, 1, 1, 32'h210, 32'h213);
    add(0, 32'h0, 26'h0, 1, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      va  = vt[i].v;
      da  = {96'd0, vt[i].w};
      aa  = vt[i].a;
      fra = vt[i].fr;
      tick();
      chk($sformatf("row%0d fill_valid", i), 64'(fva), 64'(vt[i].efv));
      chk($sformatf("row%0d ready", i), 64'(rdya), 64'(vt[i].erdy));
      chk($sformatf("row%0d busy", i), 64'(busya), 64'(vt[i].ebusy));
      if (vt[i].efv) begin
        chk($sformatf("row%0d fill_addr", i), 64'(faa), 64'(vt[i].efa));
        chk($sformatf("row%0d word0", i), 64'(fda[31:0]), 64'(vt[i].ed0));
        chk($sformatf("row%0d word3", i), 64'(fda[3*128 +: 32]), 64'(vt[i].ed3));
      end
    end
    va = 0;
    fra = 1'b1;

    // Tag error: beat 2 of line 0x20 carries 0x21
    beat_a(32'h501, 26'h20);
    beat_a(32'h502, 26'h20);
    chk("tag before bad beat", 64'(taga), 64'd0);
    beat_a(32'h503, 26'h21);
    chk("tag set", 64'(taga), 64'd1);
    beat_a(32'h504, 26'h20);
    chk("tag sticky at fill", 64'(taga), 64'd1);
    chk("tag line valid", 64'(fva), 64'd1);
    chk("tag line addr", 64'(faa), 64'h20);
    chk("tag line word2", 64'(fda[2*128 +: 32]), 64'h503);
    tick();
    chk("tag sticky idle", 64'(taga), 64'd1);

    // Reset mid-line
    beat_a(32'h901, 26'h30);
    beat_a(32'h902, 26'h30);
    reset = 1'b0;
    #1;
    chk("midrst fill_valid", 64'(fva), 64'd0);
    chk("midrst tag_err", 64'(taga), 64'd0);
    chk("midrst busy", 64'(busya), 64'd0);
    chk("midrst ready", 64'(rdya), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("post-rst no fill", 64'(fva), 64'd0);
    chk("post-rst busy", 64'(busya), 64'd0);
    beat_a(32'h301, 26'h31);
    beat_a(32'h302, 26'h31);
    beat_a(32'h303, 26'h31);
    chk("post-rst early fill", 64'(fva), 64'd0);
    beat_a(32'h304, 26'h31);
    chk("post-rst fill_valid", 64'(fva), 64'd1);
    chk("post-rst fill_addr", 64'(faa), 64'h31);
    chk("post-rst word0", 64'(fda[31:0]), 64'h301);
    chk("post-rst word1", 64'(fda[128 +: 32]), 64'h302);
    chk("post-rst word3", 64'(fda[3*128 +: 32]), 64'h304);
    tick();

    // Single-beat instance under a stalled bank
    frb = 1'b0;
    vb = 1'b1; db = {480'd0, 32'hA1}; ab = 26'h40;
    tick();
    chk("b1 first fill_valid", 64'(fvb), 64'd1);
    chk("b1 first fill_addr", 64'(fab), 64'h40);
    chk("b1 first data", 64'(fdb[31:0]), 64'hA1);
    chk("b1 ready after first", 64'(rdyb), 64'd1);
    db = {480'd0, 32'hA2}; ab = 26'h41;
    tick();
    chk("b1 full ready", 64'(rdyb), 64'd0);
    chk("b1 held addr", 64'(fab), 64'h40);
    db = {480'd0, 32'hA3}; ab = 26'h42;
    tick();
    chk("b1 refused ready", 64'(rdyb), 64'd0);
    chk("b1 still held", 64'(fab), 64'h40);
    vb = 1'b0; frb = 1'b1;
    tick();
    chk("b1 second valid", 64'(fvb), 64'd1);
    chk("b1 second addr", 64'(fab), 64'h41);
    chk("b1 second data", 64'(fdb[31:0]), 64'hA2);
    chk("b1 ready back", 64'(rdyb), 64'd1);
    tick();
    chk("b1 drained", 64'(fvb), 64'd0);
    chk("b1 idle", 64'(busyb), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
